// File: rtl/serial_frame_pkg.sv
// serial_frame_pkg
//   Shared definitions for the serial frame transmitter:
//     - DATA_W_DEFAULT : default payload width
//     - IDLE_LEVEL / START_LEVEL / STOP_LEVEL : line levels driven on sdo
//     - state_t        : transmitter FSM state encoding
//     - cnt_width()    : bit-counter width for a given payload width
//   The PARITY state exists only when SERIAL_FRAME_TX_PARITY_EN is defined.
package serial_frame_pkg;

  localparam int DATA_W_DEFAULT = 8;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef SERIAL_FRAME_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

  // A one-bit payload still needs a one-bit counter.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_frame_tx_bit_counter.sv
// bit_counter
//   Enable-gated data-bit counter. Runs from 0 up to MAX-1 and then holds
//   there; tc flags the last count.
//   Ports:
//     clk  - clock
//     rst  - synchronous active-high reset (count to 0)
//     clr  - synchronous clear (count to 0)
//     inc  - advance by one when not already at terminal count
//     tc   - high while count == MAX-1
module bit_counter
  import serial_frame_pkg::*;
#(
  parameter int MAX = DATA_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int W = cnt_width(MAX);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_reg <= '0;
    end else if (inc && !tc) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign tc = (cnt_reg == W'(MAX - 1));

endmodule

// File: rtl/serial_frame_tx.sv
// serial_frame_tx
//   Serialises one DATA_W-bit payload per frame onto sdo:
//     start (0), DATA_W data bits, optional even parity bit, stop (1).
//   Bits advance only on clock edges where en=1; the accept edge itself
//   ignores en. sdo is registered and idles high.
//   Optional feature: define SERIAL_FRAME_TX_PARITY_EN to insert a parity
//   bit (XOR of the payload) between the last data bit and stop.
//   Parameters:
//     DATA_W    - payload width (1..16)
//     MSB_FIRST - 0: LSB first, 1: MSB first
//   Ports:
//     clk     - clock
//     rst     - synchronous active-high reset, aborts any frame
//     en      - bit-advance enable
//     data_in - payload, captured on acceptance
//     valid   - payload offer strobe
//     ready   - high only when idle (accepts on valid & ready)
//     sdo     - serial output
//     busy    - high while a frame is in progress
//     done    - one-cycle pulse in the first idle cycle after a frame
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEFAULT,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid,
  output logic              ready,
  output logic              sdo,
  output logic              busy,
  output logic              done
);

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] shift_reg;
  logic              sdo_reg, sdo_next;
  logic              done_reg, done_next;
  logic              emit;
  logic              accept;
  logic              bit_last;
  logic              head_bit;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  logic              parity_reg;
`endif

  assign accept   = (state_reg == ST_IDLE) && valid;
  assign head_bit = MSB_FIRST ? shift_reg[DATA_W-1] : shift_reg[0];

  bit_counter #(
    .MAX (DATA_W)
  ) u_bit_counter (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .inc (en && (state_reg == ST_DATA)),
    .tc  (bit_last)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (valid) state_next = ST_START;
      ST_START: if (en)    state_next = ST_DATA;
      ST_DATA: begin
        if (en && bit_last) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
          state_next = ST_PARITY;
`else
          state_next = ST_STOP;
`endif
        end
      end
`ifdef SERIAL_FRAME_TX_PARITY_EN
      ST_PARITY: if (en) state_next = ST_STOP;
`endif
      ST_STOP:  if (en)    state_next = ST_IDLE;
      default:             state_next = ST_IDLE;
    endcase
  end

  // Output logic: sdo is registered to the level of the state being
  // entered. Landing in DATA with en=1 always means a fresh data bit is
  // presented (from START or from the previous bit), so take the head of
  // the shift register and shift it out.
  always_comb begin
    sdo_next  = sdo_reg;
    emit      = 1'b0;
    done_next = (state_reg == ST_STOP) && en;
    case (state_next)
      ST_IDLE:  sdo_next = IDLE_LEVEL;
      ST_START: sdo_next = START_LEVEL;
      ST_DATA: begin
        if (en) begin
          sdo_next = head_bit;
          emit     = 1'b1;
        end
      end
`ifdef SERIAL_FRAME_TX_PARITY_EN
      ST_PARITY: sdo_next = parity_reg;
`endif
      ST_STOP:  sdo_next = STOP_LEVEL;
      default:  sdo_next = IDLE_LEVEL;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= '0;
      sdo_reg   <= IDLE_LEVEL;
      done_reg  <= 1'b0;
    end else begin
      sdo_reg  <= sdo_next;
      done_reg <= done_next;
      if (accept) begin
        shift_reg <= data_in;
      end else if (emit) begin
        shift_reg <= MSB_FIRST ? (shift_reg << 1) : (shift_reg >> 1);
      end
    end
  end

`ifdef SERIAL_FRAME_TX_PARITY_EN
  // Parity is taken from the whole payload at acceptance because the
  // shift register is consumed while the data bits go out.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_reg <= 1'b0;
    end else if (accept) begin
      parity_reg <= ^data_in;
    end
  end
`endif

  assign sdo   = sdo_reg;
  assign done  = done_reg;
  assign busy  = (state_reg != ST_IDLE);
  assign ready = ~busy;

endmodule

// File: tb/tb_serial_frame_tx.sv
module tb_serial_frame_tx;

  localparam int DW = 8;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FLEN = DW + 2 + PAR;

  logic          clk = 1'b0;
  logic          rst, en, valid;
  logic [DW-1:0] data_in;
  logic          ready_a, sdo_a, busy_a, done_a;
  logic          ready_b, sdo_b, busy_b, done_b;

  always #5 clk = ~clk;

  // Same stimulus into an LSB-first and an MSB-first instance.
  serial_frame_tx #(.DATA_W(DW), .MSB_FIRST(1'b0)) dut_a (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in), .valid(valid),
    .ready(ready_a), .sdo(sdo_a), .busy(busy_a), .done(done_a));

  serial_frame_tx #(.DATA_W(DW), .MSB_FIRST(1'b1)) dut_b (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in), .valid(valid),
    .ready(ready_b), .sdo(sdo_b), .busy(busy_b), .done(done_b));

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;

  task automatic cmp1(input string nm, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: on acceptance build the whole frame as a list of
  // line levels, then walk one position per enabled edge.
  logic m_bits_a [DW+3];
  logic m_bits_b [DW+3];
  int   m_pos = 0;
  logic m_busy = 1'b0, m_done = 1'b0, m_sdo_a = 1'b1, m_sdo_b = 1'b1;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_sdo_a = 1'b1; m_sdo_b = 1'b1;
    end else if (!m_busy) begin
      m_done = 1'b0;
      if (valid) begin
        m_bits_a[0] = 1'b0;
        m_bits_b[0] = 1'b0;
        for (int i = 0; i < DW; i++) begin
          m_bits_a[1+i] = data_in[i];
          m_bits_b[1+i] = data_in[DW-1-i];
        end
        if (PAR == 1) begin
          m_bits_a[DW+1] = ^data_in;
          m_bits_b[DW+1] = ^data_in;
        end
        m_bits_a[FLEN-1] = 1'b1;
        m_bits_b[FLEN-1] = 1'b1;
        m_busy = 1'b1;
        m_pos = 0;
        m_sdo_a = m_bits_a[0];
        m_sdo_b = m_bits_b[0];
      end else begin
        m_sdo_a = 1'b1; m_sdo_b = 1'b1;
      end
    end else begin
      m_done = 1'b0;
      if (en) begin
        if (m_pos == FLEN - 1) begin
          m_busy = 1'b0; m_done = 1'b1; m_sdo_a = 1'b1; m_sdo_b = 1'b1;
        end else begin
          m_pos++;
          m_sdo_a = m_bits_a[m_pos];
          m_sdo_b = m_bits_b[m_pos];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      cmp1("sdo_a", sdo_a, m_sdo_a);
      cmp1("busy_a", busy_a, m_busy);
      cmp1("ready_a", ready_a, !m_busy);
      cmp1("done_a", done_a, m_done);
      cmp1("sdo_b", sdo_b, m_sdo_b);
      cmp1("busy_b", busy_b, m_busy);
      cmp1("ready_b", ready_b, !m_busy);
      cmp1("done_b", done_b, m_done);
    end
  end

  // Send one frame with en=1, record sdo of both instances cycle by cycle
  // and compare against hand-written sequences (first bit = MSB of exp).
  // inj>0 offers 0x55 on that cycle while the frame is running.
  task automatic check_frame(input logic [7:0] d, input logic [15:0] ea,
                             input logic [15:0] eb, input int inj, input string nm);
    logic [15:0] ca, cb;
    int done_at;
    ca = '0; cb = '0; done_at = 0;
    valid = 1'b1; data_in = d; en = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= FLEN + 2; k++) begin
      if (k == inj) begin
        valid = 1'b1; data_in = 8'h55;
      end else begin
        valid = 1'b0;
      end
      if (k <= FLEN) begin
        ca = {ca[14:0], sdo_a};
        cb = {cb[14:0], sdo_b};
      end
      if (done_a && done_at == 0) done_at = k;
      if (k < FLEN + 2) @(negedge clk);
    end
    cmp16({nm, "_seq_a"}, ca, ea);
    cmp16({nm, "_seq_b"}, cb, eb);
    cmp16({nm, "_done_cycle"}, 16'(done_at), 16'(FLEN + 1));
    cmp1({nm, "_idle_after"}, busy_a, 1'b0);
  endtask

  initial begin
    int done_at;
    rst = 1'b1; en = 1'b0; valid = 1'b0; data_in = '0;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    cmp1("rst_sdo", sdo_a, 1'b1);
    cmp1("rst_ready", ready_a, 1'b1);
    cmp1("rst_busy", busy_a, 1'b0);
    cmp1("rst_done", done_a, 1'b0);
    rst = 1'b0;
    @(negedge clk);

`ifdef SERIAL_FRAME_TX_PARITY_EN
    check_frame(8'hA5, 16'b01010010101, 16'b01010010101, 0, "a5");
    check_frame(8'h0F, 16'b01111000001, 16'b00000111101, 3, "0f_inj55");
    check_frame(8'h81, 16'b01000000101, 16'b01000000101, 0, "81");
    check_frame(8'h07, 16'b01110000011, 16'b00000011111, 0, "07_par");
    check_frame(8'h03, 16'b01100000001, 16'b00000001101, 0, "03_par");
`else
    check_frame(8'hA5, 16'b0101001011, 16'b0101001011, 0, "a5");
    check_frame(8'h0F, 16'b0111100001, 16'b0000011111, 3, "0f_inj55");
    check_frame(8'h81, 16'b0100000011, 16'b0100000011, 0, "81");
`endif

    // en toggling: every frame position lasts two cycles.
    valid = 1'b1; data_in = 8'h3C; en = 1'b1;
    @(negedge clk);
    valid = 1'b0; done_at = 0;
    for (int k = 1; k <= 2 * FLEN + 3; k++) begin
      en = (k % 2 == 0);
      if (done_a && done_at == 0) done_at = k;
      @(negedge clk);
    end
    cmp16("3c_toggle_done_cycle", 16'(done_at), 16'(2 * FLEN + 1));
    en = 1'b1;

    // Reset while data bit 4 of 0xFF is on the line.
    valid = 1'b1; data_in = 8'hFF;
    @(negedge clk);
    valid = 1'b0;
    repeat (5) @(negedge clk);
    cmp1("ff_bit4", sdo_a, 1'b1);
    cmp1("ff_busy_mid", busy_a, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cmp1("abort_sdo", sdo_a, 1'b1);
    cmp1("abort_ready", ready_a, 1'b1);
    cmp1("abort_busy", busy_a, 1'b0);
    cmp1("abort_done", done_a, 1'b0);
    for (int k = 0; k < FLEN; k++) begin
      @(negedge clk);
      cmp1("abort_no_done", done_a, 1'b0);
    end

    // Randomised traffic, checked cycle by cycle against the model.
    for (int n = 0; n < 3000; n++) begin
      en      = ($urandom_range(0, 3) != 0);
      valid   = ($urandom_range(0, 3) == 0);
      data_in = 8'($urandom);
      rst     = ($urandom_range(0, 149) == 0);
      @(negedge clk);
    end
    rst = 1'b0; en = 1'b1; valid = 1'b0;
    repeat (2 * FLEN) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
